// File: rtl/scv_rominit_seq.sv
// Splits one host download stream into the boot/chr/apu/cart ROM-init ports of the scv core
// and holds the core in reset until a complete load has been written.
module scv_rominit_seq #(
    parameter int unsigned BOOT_SIZE  = 4096,
    parameter int unsigned CHR_SIZE   = 1024,
    parameter int unsigned APU_SIZE   = 2048,
    parameter int unsigned CART_MAX   = 33554432,
    parameter int unsigned RESET_HOLD = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic        dl_start,
    input  logic        dl_valid,
    input  logic [7:0]  dl_data,
    input  logic        dl_last,
    output logic        dl_ready,
    output logic        rominit_sel_boot,
    output logic        rominit_sel_chr,
    output logic        rominit_sel_apu,
    output logic        rominit_sel_cart,
    output logic [24:0] rominit_addr,
    output logic [7:0]  rominit_data,
    output logic        rominit_valid,
    output logic [24:0] cart_size,
    output logic        core_resb,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned OFF_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1) + 1;

    // sel encoding: [3]=boot [2]=chr [1]=apu [0]=cart
    localparam logic [3:0] SEL_BOOT = 4'b1000;
    localparam logic [3:0] SEL_CHR  = 4'b0100;
    localparam logic [3:0] SEL_APU  = 4'b0010;
    localparam logic [3:0] SEL_CART = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE, S_BOOT, S_CHR, S_APU, S_CART, S_HOLD, S_RUN, S_ERR
    } state_t;

    state_t              state, state_nxt;
    logic [OFF_W-1:0]    off, off_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [3:0]          sel_q, sel_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [7:0]          data_q, data_nxt;
    logic                valid_q, valid_nxt;
    logic [ADDR_W-1:0]   cart_size_q, cart_size_nxt;
    logic                resb_q, done_q, err_q;

    logic                accept;
    logic [OFF_W-1:0]    region_last;
    logic [3:0]          region_sel;
    state_t              region_next;

    assign dl_ready = (state inside {S_BOOT, S_CHR, S_APU, S_CART}) && !dl_start;
    assign accept   = dl_ready && dl_valid;

    // Fixed-size region decode for the three firmware images
    always_comb begin
        region_last = OFF_W'(BOOT_SIZE - 1);
        region_sel  = SEL_BOOT;
        region_next = S_CHR;
        case (state)
            S_CHR: begin
                region_last = OFF_W'(CHR_SIZE - 1);
                region_sel  = SEL_CHR;
                region_next = S_APU;
            end
            S_APU: begin
                region_last = OFF_W'(APU_SIZE - 1);
                region_sel  = SEL_APU;
                region_next = S_CART;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        off_nxt       = off;
        hold_nxt      = hold_cnt;
        sel_nxt       = sel_q;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        valid_nxt     = 1'b0;
        cart_size_nxt = cart_size_q;
        if (dl_start) begin
            state_nxt     = S_BOOT;
            off_nxt       = '0;
            cart_size_nxt = '0;
            sel_nxt       = '0;
        end else begin
            case (state)
                S_BOOT, S_CHR, S_APU: begin
                    if (accept) begin
                        valid_nxt = 1'b1;
                        data_nxt  = dl_data;
                        addr_nxt  = ADDR_W'(off);
                        sel_nxt   = region_sel;
                        if (off == region_last) begin
                            off_nxt   = '0;
                            state_nxt = region_next;
                        end else begin
                            off_nxt = off + OFF_W'(1);
                        end
                        // Only the final APU byte may end a stream that carries no cart
                        if (dl_last) begin
                            if (state == S_APU && off == region_last) begin
                                state_nxt = S_HOLD;
                                hold_nxt  = '0;
                            end else begin
                                state_nxt = S_ERR;
                            end
                        end
                    end
                end
                S_CART: begin
                    if (accept) begin
                        // Bytes beyond CART_MAX are swallowed; offset saturates there
                        if (off < OFF_W'(CART_MAX)) begin
                            valid_nxt     = 1'b1;
                            data_nxt      = dl_data;
                            addr_nxt      = ADDR_W'(off);
                            sel_nxt       = SEL_CART;
                            cart_size_nxt = ADDR_W'(off + OFF_W'(1));
                            off_nxt       = off + OFF_W'(1);
                        end
                        if (dl_last) begin
                            state_nxt = S_HOLD;
                            hold_nxt  = '0;
                        end
                    end
                end
                S_HOLD: begin
                    sel_nxt = '0;
                    if (hold_cnt == HOLD_W'(RESET_HOLD)) begin
                        state_nxt = S_RUN;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= S_IDLE;
            off         <= '0;
            hold_cnt    <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            cart_size_q <= '0;
            resb_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            off         <= off_nxt;
            hold_cnt    <= hold_nxt;
            sel_q       <= sel_nxt;
            addr_q      <= addr_nxt;
            data_q      <= data_nxt;
            valid_q     <= valid_nxt;
            cart_size_q <= cart_size_nxt;
            resb_q      <= (state_nxt == S_RUN);
            done_q      <= (state_nxt == S_RUN);
            err_q       <= (state_nxt == S_ERR);
        end
    end

    assign rominit_sel_boot = sel_q[3];
    assign rominit_sel_chr  = sel_q[2];
    assign rominit_sel_apu  = sel_q[1];
    assign rominit_sel_cart = sel_q[0];
    assign rominit_addr     = addr_q;
    assign rominit_data     = data_q;
    assign rominit_valid    = valid_q;
    assign cart_size        = cart_size_q;
    assign core_resb        = resb_q;
    assign load_done        = done_q;
    assign load_err         = err_q;

endmodule

// File: tb/tb_scv_rominit_seq.sv
// Scoreboard bench for scv_rominit_seq: driver queues expected ROM writes, monitor checks them.
module tb_scv_rominit_seq;

    localparam int BOOT_N = 4096;
    localparam int CHR_N  = 1024;
    localparam int APU_N  = 2048;
    localparam int CART_M = 256;
    localparam int FW_N   = BOOT_N + CHR_N + APU_N;

    logic        clk = 1'b0;
    logic        res;
    logic        dl_start, dl_valid, dl_last;
    logic [7:0]  dl_data;
    logic        dl_ready;
    logic        sel_boot, sel_chr, sel_apu, sel_cart;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_valid;
    logic [24:0] cart_size;
    logic        core_resb, load_done, load_err;

    typedef struct {
        logic [3:0]  sel;
        logic [24:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen_cart = 0;

    scv_rominit_seq #(.CART_MAX(CART_M)) dut (
        .clk(clk), .res(res), .dl_start(dl_start), .dl_valid(dl_valid),
        .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready),
        .rominit_sel_boot(sel_boot), .rominit_sel_chr(sel_chr),
        .rominit_sel_apu(sel_apu), .rominit_sel_cart(sel_cart),
        .rominit_addr(rom_addr), .rominit_data(rom_data), .rominit_valid(rom_valid),
        .cart_size(cart_size), .core_resb(core_resb), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        return 8'(i * 13 + 5);
    endfunction

    // Expected write for stream index i; returns 0 if the byte must not be written
    function automatic bit model_at(input int i, output exp_t e);
        e.data = byte_at(i);
        e.cyc  = 0;
        if (i < BOOT_N) begin
            e.sel = 4'b1000; e.addr = 25'(i);
        end else if (i < BOOT_N + CHR_N) begin
            e.sel = 4'b0100; e.addr = 25'(i - BOOT_N);
        end else if (i < FW_N) begin
            e.sel = 4'b0010; e.addr = 25'(i - BOOT_N - CHR_N);
        end else begin
            e.sel = 4'b0001; e.addr = 25'(i - FW_N);
            return (i - FW_N) < CART_M;
        end
        return 1'b1;
    endfunction

    // Monitor: every ROM write must match the oldest queued expectation, one cycle after issue
    always @(negedge clk) begin
        if (!res) begin
            if (sel_cart) seen_cart = 1'b1;
            if (rom_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write sel=%b addr=%0d data=%0h",
                             {sel_boot, sel_chr, sel_apu, sel_cart}, rom_addr, rom_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({sel_boot, sel_chr, sel_apu, sel_cart} !== e.sel || rom_addr !== e.addr ||
                        rom_data !== e.data || cyc != e.cyc + 1) begin
                        bad++;
                        $display("FAIL rom_write actual sel=%b addr=%0d data=%0h cyc=%0d required sel=%b addr=%0d data=%0h cyc=%0d",
                                 {sel_boot, sel_chr, sel_apu, sel_cart}, rom_addr, rom_data, cyc,
                                 e.sel, e.addr, e.data, e.cyc + 1);
                    end
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        dl_start = 1'b1; dl_valid = 1'b1; dl_data = 8'hA5; dl_last = 1'b0;
        #1 chk("ready_in_start", 32'(dl_ready), 32'd0);
        @(negedge clk);
        dl_start = 1'b0; dl_valid = 1'b0;
        #1;
        chk("start_valid", 32'(rom_valid), 32'd0);
        chk("start_sel", 32'({sel_boot, sel_chr, sel_apu, sel_cart}), 32'd0);
        chk("start_resb", 32'(core_resb), 32'd0);
        chk("start_err", 32'(load_err), 32'd0);
        chk("start_done", 32'(load_done), 32'd0);
        chk("start_cart_size", 32'(cart_size), 32'd0);
        chk("start_ready", 32'(dl_ready), 32'd1);
    endtask

    task automatic stream(input int n, input int last_at, input bit toggle);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dl_valid = 1'b1; dl_data = byte_at(i); dl_last = (i == last_at);
            if (model_at(i, e)) begin
                e.cyc = cyc;
                exp_q.push_back(e);
            end
            if (toggle) begin
                @(negedge clk);
                dl_valid = 1'b0; dl_last = 1'b0;
            end
        end
        if (!toggle) begin
            @(negedge clk);
            dl_valid = 1'b0; dl_last = 1'b0;
        end
    endtask

    // Counts cycles from the final byte's output cycle until the core leaves reset
    task automatic wait_run(input string name);
        int j = 0;
        while (!core_resb && j < 40) begin
            @(negedge clk);
            j++;
            if (j == 1) chk({name, "_sel_drop"}, 32'({sel_boot, sel_chr, sel_apu, sel_cart}), 32'd0);
        end
        chk({name, "_resb_delay"}, 32'(j), 32'd17);
        chk({name, "_done"}, 32'(load_done), 32'd1);
        chk({name, "_ready_run"}, 32'(dl_ready), 32'd0);
    endtask

    initial begin
        res = 1'b1; dl_start = 1'b0; dl_valid = 1'b0; dl_last = 1'b0; dl_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_resb", 32'(core_resb), 32'd0);
        chk("rst_ready", 32'(dl_ready), 32'd0);
        chk("rst_sel", 32'({sel_boot, sel_chr, sel_apu, sel_cart}), 32'd0);
        chk("rst_valid", 32'(rom_valid), 32'd0);
        chk("rst_cart_size", 32'(cart_size), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_done_err", 32'({load_done, load_err}), 32'd0);
        res = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(dl_ready), 32'd0);

        // Full load, last byte is the final writable cart byte
        do_start();
        stream(FW_N + CART_M, FW_N + CART_M - 1, 1'b0);
        wait_run("full");
        chk("full_cart_size", 32'(cart_size), 32'(CART_M));
        chk("full_err", 32'(load_err), 32'd0);
        chk("full_queue", 32'(exp_q.size()), 32'd0);

        // Gapped stream across the boot->chr boundary, then restart mid-load
        do_start();
        stream(BOOT_N + 104, -1, 1'b1);
        repeat (2) @(negedge clk);
        chk("gap_queue", 32'(exp_q.size()), 32'd0);

        // Early LAST in CHR at offset 100
        do_start();
        stream(BOOT_N + 101, BOOT_N + 100, 1'b0);
        chk("err_flag", 32'(load_err), 32'd1);
        chk("err_ready", 32'(dl_ready), 32'd0);
        chk("err_resb", 32'(core_resb), 32'd0);
        dl_valid = 1'b1; dl_data = 8'h3C;
        repeat (3) @(negedge clk);
        dl_valid = 1'b0;
        @(negedge clk);
        chk("err_sticky", 32'(load_err), 32'd1);
        chk("err_queue", 32'(exp_q.size()), 32'd0);
        do_start();

        // LAST on final APU byte: no cart
        seen_cart = 1'b0;
        stream(FW_N, FW_N - 1, 1'b0);
        wait_run("nocart");
        chk("nocart_size", 32'(cart_size), 32'd0);
        chk("nocart_sel_cart", 32'(seen_cart), 32'd0);
        chk("nocart_queue", 32'(exp_q.size()), 32'd0);

        // Restart after 500 cart bytes, then an oversized cart
        do_start();
        stream(FW_N + 500, -1, 1'b0);
        chk("over_cart_size", 32'(cart_size), 32'(CART_M));
        chk("over_sel_cart", 32'(sel_cart), 32'd1);
        chk("over_err", 32'(load_err), 32'd0);
        do_start();
        stream(FW_N + 300, FW_N + 299, 1'b0);
        wait_run("over");
        chk("over2_cart_size", 32'(cart_size), 32'(CART_M));
        chk("over2_err", 32'(load_err), 32'd0);
        chk("over2_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-load returns outputs to reset values
        do_start();
        stream(10, -1, 1'b0);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        exp_q.delete();
        chk("midrst_ready", 32'(dl_ready), 32'd0);
        chk("midrst_sel", 32'({sel_boot, sel_chr, sel_apu, sel_cart}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
